odd_seq_monitor: RTL and testbench

Downstream checker for the 8-bit odd counter stage. Samples the counter value every clock, acquires lock on the 1, 3, 5, …, 255, 1 sequence, then flags each departure from it. Also counts errors and wrap-arounds. Used as an on-chip self-check and as the reference model consumer in the counter's bench.

---
 rtl/odd_seq_monitor.sv | 139 +++++++++++++
 tb/tb_odd_seq_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/odd_seq_monitor.sv
// -----------------------------------------------------------------------------
// odd_seq_monitor
//
// Downstream checker for the 8-bit odd counter stage. Every rising edge it
// samples the counter value, acquires lock on the 1, 3, 5, ..., 255, 1
// sequence, and then flags every departure from that sequence. It also keeps
// a saturating error count and a free-running count of accepted wrap-arounds.
//
// There is no handshake: cnt_i is treated as valid on every rising edge, and
// every output is registered and updates once per sample.
//
// Parameters
//   LOCK_LEN   : consecutive correct samples needed to declare lock (2..15)
//
// Ports
//   clk        : rising-edge clock, shared with the odd counter
//   reset      : synchronous, active-high reset (discards the sample on its edge)
//   cnt_i      : counter value from the upstream odd counter
//   locked_o   : high while the monitor is in TRACK
//   err_o      : one-cycle pulse per sequence violation seen in TRACK
//   wrap_o     : one-cycle pulse when a 255 -> 1 step is accepted in TRACK
//   err_cnt_o  : total errors, saturating at 255
//   wrap_cnt_o : total accepted wraps, modulo 2^16
//   state_dbg  : current FSM state (0 = IDLE, 1 = ACQ, 2 = TRACK)
// -----------------------------------------------------------------------------
module odd_seq_monitor #(
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cnt_i,
  output logic        locked_o,
  output logic        err_o,
  output logic        wrap_o,
  output logic [7:0]  err_cnt_o,
  output logic [15:0] wrap_cnt_o,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  // The run counter holds the number of correct samples seen so far in ACQ.
  // Lock is declared on the sample that brings it to LOCK_LEN, i.e. when the
  // current value equals LOCK_LEN - 1 and the sample matches.
  localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN - 1);

  state_t     state;
  logic [7:0] exp_val;   // expected next sample
  logic [3:0] run;       // acquisition run length

  logic       match;
  logic [7:0] seed;

  // On a match cnt_i equals exp_val, so cnt_i + 2 serves both as the next
  // expected value and as the re-seed value. 8-bit truncation makes 255 + 2
  // come out as 1, which is the only wrap handling needed.
  assign match = (cnt_i == exp_val);
  assign seed  = cnt_i + 8'd2;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      exp_val    <= 8'd0;
      run        <= 4'd0;
      locked_o   <= 1'b0;
      err_o      <= 1'b0;
      wrap_o     <= 1'b0;
      err_cnt_o  <= 8'd0;
      wrap_cnt_o <= 16'd0;
    end else begin
      // Pulses default low; they are raised only for the sample that causes them.
      err_o  <= 1'b0;
      wrap_o <= 1'b0;

      case (state)
        IDLE: begin
          if (cnt_i[0]) begin
            exp_val <= seed;
            run     <= 4'd1;
            state   <= ACQ;
          end
        end

        ACQ: begin
          if (match) begin
            exp_val <= seed;
            run     <= run + 4'd1;
            if (run == LOCK_RUN) begin
              state    <= TRACK;
              locked_o <= 1'b1;
            end
          end else if (cnt_i[0]) begin
            // An odd mismatch starts a fresh acquisition from this sample.
            exp_val <= seed;
            run     <= 4'd1;
          end else begin
            state <= IDLE;
          end
        end

        TRACK: begin
          if (match) begin
            exp_val <= seed;
            // Accepting a 1 in TRACK means the previous accepted value was 255.
            if (cnt_i == 8'd1) begin
              wrap_o     <= 1'b1;
              wrap_cnt_o <= wrap_cnt_o + 16'd1;
            end
          end else begin
            err_o    <= 1'b1;
            locked_o <= 1'b0;
            if (err_cnt_o != 8'hFF) begin
              err_cnt_o <= err_cnt_o + 8'd1;
            end
            if (cnt_i[0]) begin
              exp_val <= seed;
              run     <= 4'd1;
              state   <= ACQ;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state    <= IDLE;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odd_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_odd_seq_monitor
//
// Directed bench for odd_seq_monitor with LOCK_LEN = 4. Inputs are driven 1 ns
// after each rising edge and outputs are sampled 1 ns after the following
// edge, so each step() call applies one sample and exposes its result.
// -----------------------------------------------------------------------------
module tb_odd_seq_monitor;

  localparam int unsigned LOCK_LEN = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic [7:0]  cnt;
  logic        locked;
  logic        err;
  logic        wrap;
  logic [7:0]  err_cnt;
  logic [15:0] wrap_cnt;
  logic [1:0]  state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  odd_seq_monitor #(
    .LOCK_LEN (LOCK_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_i      (cnt),
    .locked_o   (locked),
    .err_o      (err),
    .wrap_o     (wrap),
    .err_cnt_o  (err_cnt),
    .wrap_cnt_o (wrap_cnt),
    .state_dbg  (state_dbg)
  );

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one sample, wait for the edge that takes it, settle 1 ns.
  // ---------------------------------------------------------------------------
  task automatic step(input logic [7:0] v);
    cnt = v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic l, input logic e,
                               input logic w, input logic [7:0] ec,
                               input logic [15:0] wc, input logic [1:0] st);
    check({tag, ".locked"},   32'(locked),    32'(l));
    check({tag, ".err"},      32'(err),       32'(e));
    check({tag, ".wrap"},     32'(wrap),      32'(w));
    check({tag, ".err_cnt"},  32'(err_cnt),   32'(ec));
    check({tag, ".wrap_cnt"}, 32'(wrap_cnt),  32'(wc));
    check({tag, ".state"},    32'(state_dbg), 32'(st));
  endtask

  int exp_err;

  initial begin
    reset = 1'b1;
    cnt   = 8'd0;
    @(posedge clk);
    #1;
    step(8'd1);
    step(8'd3);
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, ST_IDLE);
    reset = 1'b0;

    // ---- Clean lock: 1,3,5,7,9 -----------------------------------------
    step(8'd1);
    check_outputs("lock_s1", 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, ST_ACQ);
    step(8'd3);
    check("lock_s3.locked", 32'(locked), 32'd0);
    step(8'd5);
    check("lock_s5.locked", 32'(locked), 32'd0);
    step(8'd7);
    check_outputs("lock_s7", 1'b1, 1'b0, 1'b0, 8'd0, 16'd0, ST_TRACK);
    step(8'd9);
    check_outputs("lock_s9", 1'b1, 1'b0, 1'b0, 8'd0, 16'd0, ST_TRACK);

    // ---- Wrap: ..., 253, 255, 1, 3 -------------------------------------
    for (int v = 11; v <= 253; v += 2) step(8'(v));
    check_outputs("wrap_253", 1'b1, 1'b0, 1'b0, 8'd0, 16'd0, ST_TRACK);
    step(8'd255);
    check("wrap_255.wrap", 32'(wrap), 32'd0);
    step(8'd1);
    check_outputs("wrap_1", 1'b1, 1'b0, 1'b1, 8'd0, 16'd1, ST_TRACK);
    step(8'd3);
    check_outputs("wrap_3", 1'b1, 1'b0, 1'b0, 8'd0, 16'd1, ST_TRACK);

    // ---- Upstream reset mid-stream: 11, 13, 1, 3, 5, 7 ------------------
    for (int v = 5; v <= 13; v += 2) step(8'(v));
    check("ureset_13.locked", 32'(locked), 32'd1);
    step(8'd1);
    check_outputs("ureset_1", 1'b0, 1'b1, 1'b0, 8'd1, 16'd1, ST_ACQ);
    step(8'd3);
    check_outputs("ureset_3", 1'b0, 1'b0, 1'b0, 8'd1, 16'd1, ST_ACQ);
    step(8'd5);
    check("ureset_5.locked", 32'(locked), 32'd0);
    step(8'd7);
    check_outputs("ureset_7", 1'b1, 1'b0, 1'b0, 8'd1, 16'd1, ST_TRACK);

    // ---- Even glitch: 21, 22, (even hold), 25 ---------------------------
    for (int v = 9; v <= 21; v += 2) step(8'(v));
    step(8'd22);
    check_outputs("even_22", 1'b0, 1'b1, 1'b0, 8'd2, 16'd1, ST_IDLE);
    step(8'd24);
    check_outputs("even_24", 1'b0, 1'b0, 1'b0, 8'd2, 16'd1, ST_IDLE);
    step(8'd26);
    check_outputs("even_26", 1'b0, 1'b0, 1'b0, 8'd2, 16'd1, ST_IDLE);
    step(8'd25);
    check_outputs("even_25", 1'b0, 1'b0, 1'b0, 8'd2, 16'd1, ST_ACQ);
    step(8'd27);
    step(8'd29);
    check("even_29.locked", 32'(locked), 32'd0);
    step(8'd31);
    check_outputs("even_31", 1'b1, 1'b0, 1'b0, 8'd2, 16'd1, ST_TRACK);

    // ---- Build err_cnt = 3, wrap_cnt = 2 --------------------------------
    step(8'd33);
    step(8'd40);
    check_outputs("prep_40", 1'b0, 1'b1, 1'b0, 8'd3, 16'd1, ST_IDLE);
    step(8'd249);
    step(8'd251);
    step(8'd253);
    step(8'd255);
    check("prep_255.locked", 32'(locked), 32'd1);
    step(8'd1);
    check_outputs("prep_1", 1'b1, 1'b0, 1'b1, 8'd3, 16'd2, ST_TRACK);

    // ---- Reset mid-operation while feeding valid values -----------------
    reset = 1'b1;
    step(8'd3);
    check_outputs("midrst", 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, ST_IDLE);
    reset = 1'b0;
    step(8'd5);
    check_outputs("relock_5", 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, ST_ACQ);
    step(8'd7);
    step(8'd9);
    check("relock_9.locked", 32'(locked), 32'd0);
    step(8'd11);
    check_outputs("relock_11", 1'b1, 1'b0, 1'b0, 8'd0, 16'd0, ST_TRACK);

    // ---- Saturation: 260 TRACK errors, relocking each time --------------
    exp_err = 0;
    for (int i = 0; i < 260; i++) begin
      step(8'd0);
      exp_err = (exp_err == 255) ? 255 : exp_err + 1;
      check("sat.err",     32'(err),     32'd1);
      check("sat.err_cnt", 32'(err_cnt), 32'(exp_err));
      step(8'd1);
      step(8'd3);
      step(8'd5);
      step(8'd7);
      check("sat.relock", 32'(locked), 32'd1);
    end
    check_outputs("sat_end", 1'b1, 1'b0, 1'b0, 8'd255, 16'd0, ST_TRACK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
